pipe_adder: RTL
===============

# pipe_adder

Parametrised, pipelined ripple-carry adder with carry-in/carry-out and a valid/ready handshake on both sides. It generalises the team's fixed 8-bit combinational adder:

- Operand width is configurable.
- The carry chain is split into `STAGES` registered segments, so wide adds close timing.
- One add per cycle is accepted at full throughput.
- Downstream backpressure stalls the whole pipeline without loss.

It sits between operand producers and arithmetic consumers in the datapath.

## Interface
Parameters:
- `WIDTH`, default 8: operand and sum width in bits; must be ≥ 1.
- `STAGES`, default 2: number of pipeline segments. Must divide `WIDTH` exactly; otherwise it is an elaboration error.
  - Segment width `SEG = WIDTH/STAGES`.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `in_valid`, input, 1: operands present on `a`, `b`, `c_in`.
- `in_ready`, output, 1: the block accepts operands this cycle.
- `a`, input, `WIDTH`: operand A, unsigned.
- `b`, input, `WIDTH`: operand B, unsigned.
- `c_in`, input, 1: carry-in to bit 0.
- `sub`, input, 1: subtract mode. Present only with `PIPE_ADDER_SUB_EN`.
- `out_valid`, output, 1: `sum`/`c_out` hold a result.
- `out_ready`, input, 1: the consumer takes the result this cycle.
- `sum`, output, `WIDTH`: result bits.
- `c_out`, output, 1: carry out of bit `WIDTH-1`.

## Operation
- Transfer rules:
  - An input transfer occurs on a cycle with `in_valid && in_ready`.
  - An output transfer occurs on a cycle with `out_valid && out_ready`.
- Global advance: `adv = !out_valid || out_ready`; `in_ready = adv`.
  - When `adv = 0`, every pipeline register holds, valid bits included.
- Stage k (k = 0..`STAGES-1`):
  - Adds operand bits [k·SEG +: SEG] of A and B plus the carry registered by stage k-1 (stage 0 uses `c_in`).
  - Registers the SEG-bit partial sum, the carry out, and a valid bit.
- Operand skew and sum deskew:
  - Operand segments for stage k are delayed k cycles in skew registers.
  - Partial sums produced by earlier stages are carried forward in deskew registers, so `sum` is presented aligned.
- Each stage valid bit loads the previous stage's valid bit (stage 0 loads `in_valid`) when `adv = 1`.
- `out_valid` is the last stage's valid bit.
- Result: `{c_out, sum} = a + b + c_in`, computed at full `WIDTH+1` precision. No truncation other than dropping nothing: `c_out` is the `WIDTH+1`th bit.
- A bubble (no input transfer while `adv = 1`) propagates as `valid = 0`. Data registers may update freely in that case; their contents are don't-care when the valid bit is 0.
- Results leave in acceptance order. There is no reordering and no drop.

## Timing
- Latency: the result of an input accepted at edge N appears with `out_valid = 1` after edge N+`STAGES`, provided there is no stall.
- Throughput: one operation per cycle while `out_ready = 1`.
- Reset: all valid bits clear on the first rising edge with `rst = 1`.
  - Output values after reset: `out_valid = 0`, `sum = 0`, `c_out = 0`, `in_ready = 1`.
  - All data registers are cleared to 0.
- Reset mid-operation: every in-flight result is discarded. No output transfer occurs on or after the reset edge until new inputs traverse the pipeline.
- Stall:
  - `out_valid = 1 && out_ready = 0` forces `in_ready = 0` in the same cycle. The dependence is combinational from `out_ready`.
  - `sum` and `c_out` hold stable until the output transfer occurs.
- Simultaneous output transfer and input transfer in the same cycle is legal and sustains full throughput.
- `STAGES = 1`: single register stage, latency 1. `STAGES = WIDTH`: bit-serial carry per stage.
- Wrap-around example: `a = 2^WIDTH-1`, `b = 0`, `c_in = 1` gives `sum = 0`, `c_out = 1`.

## Configuration
- Macro `PIPE_ADDER_SUB_EN`.
- Defined:
  - Port `sub` exists and is sampled with the operands, travelling with them through the pipeline.
  - `sub = 1` computes `{c_out, sum} = a + ~b + !c_in`. Here `c_in` acts as borrow-in, and `c_out = 1` means no borrow.
  - `sub = 0` behaves as plain add.
- Undefined: port `sub` is absent; the block always adds.

## Test plan
All scenarios use `WIDTH = 8`, `STAGES = 2` unless stated.
- Reset, then `a = 0xFF`, `b = 0x01`, `c_in = 0`, single input transfer → two edges later `out_valid = 1`, `sum = 0x00`, `c_out = 1`.
- Back-to-back inputs (0x12+0x34+1, 0x80+0x80+0, 0x0F+0xF1+0) with `out_ready = 1` held → consecutive outputs on three cycles: 0x47/0; 0x00/1; 0x00/1.
- Stall: hold `out_ready = 0` for 3 cycles with result 0x47 pending → `in_ready = 0`, `sum` stays 0x47; after release, the queued results emerge in order with none lost.
- `rst` asserted while two results are in flight → next edge gives `out_valid = 0`, `sum = 0`; no stale result appears later.
- `WIDTH = 32`, `STAGES = 4`: 1000 random operands checked against a 33-bit reference model, with random `out_ready` and `in_valid`; latency of 4 checked on an unstalled op.
- With `PIPE_ADDER_SUB_EN`: `sub = 1`, `a = 0x05`, `b = 0x07`, `c_in = 0` → `sum = 0xFE`, `c_out = 0`; `a = 0x07`, `b = 0x05` → `sum = 0x02`, `c_out = 1`.

Source files
------------

// File: rtl/pipe_adder.sv
// pipe_adder: WIDTH-bit ripple-carry adder cut into STAGES registered carry segments; `PIPE_ADDER_SUB_EN adds a subtract port.
// Latency: STAGES cycles from input transfer to out_valid; one result per cycle at full throughput.
// Backpressure: out_valid && !out_ready freezes every stage and drops in_ready combinationally.
module pipe_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef PIPE_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);
    localparam int SEG = WIDTH / STAGES;

    if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipe_adder: STAGES (%0d) must divide WIDTH (%0d)", STAGES, WIDTH);
    end

    // One pipeline slot: skewed operands still to be added, deskewed partial sum, carry and valid.
    typedef struct packed {
        logic             vld;
        logic             sub;
        logic             cy;
        logic [WIDTH-1:0] op_a;
        logic [WIDTH-1:0] op_b;
        logic [WIDTH-1:0] part;
    } stage_t;

    stage_t       src     [STAGES];
    stage_t       nxt     [STAGES];
    stage_t       q       [STAGES];
    logic [SEG:0] seg_res [STAGES];
    logic         sub_in;
    logic         adv;

`ifdef PIPE_ADDER_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    assign adv       = !q[STAGES-1].vld || out_ready;
    assign in_ready  = adv;
    assign out_valid = q[STAGES-1].vld;
    assign sum       = q[STAGES-1].part;
    assign c_out     = q[STAGES-1].cy;

    // In subtract mode the incoming carry is the inverted borrow-in.
    always_comb begin
        src[0] = '{vld: in_valid, sub: sub_in, cy: c_in ^ sub_in, op_a: a, op_b: b, part: '0};
        for (int k = 1; k < STAGES; k++) begin
            src[k] = q[k-1];
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            seg_res[k] = {1'b0, src[k].op_a[k*SEG +: SEG]}
                       + {1'b0, src[k].op_b[k*SEG +: SEG] ^ {SEG{src[k].sub}}}
                       + {{SEG{1'b0}}, src[k].cy};
            nxt[k]                    = src[k];
            nxt[k].cy                 = seg_res[k][SEG];
            nxt[k].part[k*SEG +: SEG] = seg_res[k][SEG-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                q[k] <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                q[k] <= nxt[k];
            end
        end
    end
endmodule
